// File: rtl/usb_ep_pkg.sv
// Shared types and constants for the USB endpoint transaction router.
// Router FSM encoding plus upper-PID codes for handshake/data responses.
package usb_ep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_STALLED = 2'd2,
    ST_IGNORE  = 2'd3
  } EpRouterState;

  localparam logic [1:0] PID_ACK   = 2'b00;
  localparam logic [1:0] PID_NAK   = 2'b10;
  localparam logic [1:0] PID_STALL = 2'b11;
  localparam logic [1:0] PID_DATA0 = 2'b00;
  localparam logic [1:0] PID_DATA1 = 2'b10;

endpackage

// File: rtl/usb_ep_state_bank.sv
// Per-endpoint DATA0/DATA1 toggle and halt (STALL) state.
// Ports: clk_i, rst_i, halt set/clear, toggle reset-all/clear/flip masks; halt_o, toggle_o.
module usb_ep_state_bank #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] setHalt_i,
  input  logic [N-1:0] clrHalt_i,
  input  logic         togRstAll_i,
  input  logic [N-1:0] togClr_i,
  input  logic [N-1:0] togFlip_i,
  output logic [N-1:0] halt_o,
  output logic [N-1:0] toggle_o
);

  logic [N-1:0] halt_q, halt_d;
  logic [N-1:0] tog_q, tog_d;

  always_comb begin
    // set wins over clear
    halt_d = (halt_q & ~clrHalt_i) | setHalt_i;
    // reset-all > per-endpoint clear > flip
    if (togRstAll_i) tog_d = '0;
    else             tog_d = (tog_q ^ togFlip_i) & ~togClr_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      halt_q <= '0;
      tog_q  <= '0;
    end else begin
      halt_q <= halt_d;
      tog_q  <= tog_d;
    end
  end

  assign halt_o   = halt_q;
  assign toggle_o = tog_q;

endmodule

// File: rtl/vector_mux.sv
// Generic N-way mux over a flat packed vector of W-bit lanes.
// Ports: data_i (N*W lanes), sel_i (lane index), data_o (selected lane, 0 if out of range).
module vector_mux #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = 2
) (
  input  logic [N*W-1:0]   data_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [W-1:0]     data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_i == SEL_W'(i)) data_o = data_i[i*W +: W];
    end
  end

endmodule

// File: rtl/usb_ep_txn_router.sv
// Routes one PE transaction at a time to the endpoint latched at token time,
// answers invalid/halted endpoints itself, and aborts on timeout or a new token.
// Ports: PE side (token, done, byte streams, response), per-endpoint strobes and
// muxed returns, halt/toggle control from EP0 handling, halt/toggle status.
module usb_ep_txn_router
  import usb_ep_pkg::*;
#(
  parameter int                   ENDPOINTS      = 4,
  parameter int                   DATA_WID       = 8,
  parameter logic [ENDPOINTS-1:0] EP_ENABLE_MASK = '1,
  parameter logic [ENDPOINTS-1:0] EP_ISO_MASK    = '0,
  parameter int                   TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk12_i,
  input  logic                          rst_i,
  input  logic [3:0]                    epAddr_i,
  input  logic                          gotTransStartPacket_i,
  input  logic                          isSetup_i,
  input  logic                          isHostIn_i,
  input  logic                          transDone_i,
  input  logic                          transSuccess_i,
  input  logic                          writeEn_i,
  input  logic [DATA_WID-1:0]           wData_i,
  output logic                          writeFull_o,
  input  logic                          readEn_i,
  output logic [DATA_WID-1:0]           rData_o,
  output logic                          readDataAvailable_o,
  output logic                          readIsLastPacketByte_o,
  output logic                          respValid_o,
  output logic                          respIsHandshakePID_o,
  output logic [1:0]                    respPacketID_o,
  output logic [ENDPOINTS-1:0]          ep_transStart_o,
  output logic [ENDPOINTS-1:0]          ep_transDone_o,
  output logic [ENDPOINTS-1:0]          ep_transSuccess_o,
  output logic [ENDPOINTS-1:0]          ep_writeEn_o,
  output logic [DATA_WID-1:0]           ep_wData_o,
  input  logic [ENDPOINTS-1:0]          ep_full_i,
  output logic [ENDPOINTS-1:0]          ep_readEn_o,
  input  logic [ENDPOINTS*DATA_WID-1:0] ep_rData_i,
  input  logic [ENDPOINTS-1:0]          ep_dataAvailable_i,
  input  logic [ENDPOINTS-1:0]          ep_isLast_i,
  input  logic [ENDPOINTS-1:0]          ep_respValid_i,
  input  logic [ENDPOINTS-1:0]          ep_respIsHandshake_i,
  input  logic [2*ENDPOINTS-1:0]        ep_respPacketID_i,
  input  logic [ENDPOINTS-1:0]          setHalt_i,
  input  logic [ENDPOINTS-1:0]          clearHalt_i,
  input  logic                          resetDataToggle_i,
  output logic [ENDPOINTS-1:0]          epHalted_o,
  output logic [ENDPOINTS-1:0]          dataToggle_o
);

  localparam int EP_SELECT_WID =
    (ENDPOINTS > 1) ? $clog2(ENDPOINTS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT_CYCLES - 1);
  // padded to the 4-bit token address space so
  // out-of-range addresses read as disabled
  localparam logic [15:0] EP_MASK16 =
    16'(EP_ENABLE_MASK) | 16'h1;
  localparam logic [15:0] EP_ISO16 = 16'(EP_ISO_MASK);

  EpRouterState state_q, state_d;
  logic [EP_SELECT_WID-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [15:0] halt16;
  logic tok_ok, tok_setup0, tok_stall;
  logic timeout, act, done_ok, abort, flip;
  logic [ENDPOINTS-1:0] sel_oh, tok_oh;
  logic [ENDPOINTS-1:0] clr_mask;

  logic [DATA_WID-1:0] mx_rdata;
  logic mx_avail, mx_last, mx_full;
  logic mx_rv, mx_hs;
  logic [1:0] mx_pid;

  // direction is implied by which PE strobe is used
  logic unused_host_in;
  assign unused_host_in = isHostIn_i;

  assign halt16     = 16'(epHalted_o);
  assign tok_ok     = EP_MASK16[epAddr_i];
  assign tok_setup0 = isSetup_i && (epAddr_i == 4'd0);
  // SETUP to EP0 always gets through a halt
  assign tok_stall  = halt16[epAddr_i] && !tok_setup0;
  assign sel_oh     = ENDPOINTS'(1) << sel_q;
  assign tok_oh     = ENDPOINTS'(1) << epAddr_i;

  assign timeout = (cnt_q == CNT_MAX);
  assign act     = (state_q == ST_ACTIVE);
  // a new token pre-empts even a same-cycle done
  assign done_ok = act && transDone_i && !gotTransStartPacket_i;
  assign abort   = act && (gotTransStartPacket_i
                   || (!transDone_i && timeout));
  assign flip    = done_ok && transSuccess_i && !EP_ISO16[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = timeout ? cnt_q : cnt_q + 1'b1;
    if (gotTransStartPacket_i) begin
      sel_d = epAddr_i[EP_SELECT_WID-1:0];
      cnt_d = '0;
      if (!tok_ok)        state_d = ST_IGNORE;
      else if (tok_stall) state_d = ST_STALLED;
      else                state_d = ST_ACTIVE;
    end else if (state_q != ST_IDLE
                 && (transDone_i || timeout)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clr_mask = clearHalt_i
    | ENDPOINTS'(gotTransStartPacket_i && tok_setup0);

  usb_ep_state_bank #(.N(ENDPOINTS)) u_bank (
    .clk_i       (clk12_i),
    .rst_i       (rst_i),
    .setHalt_i   (setHalt_i),
    .clrHalt_i   (clr_mask),
    .togRstAll_i (resetDataToggle_i),
    .togClr_i    (clr_mask),
    .togFlip_i   (flip ? sel_oh : '0),
    .halt_o      (epHalted_o),
    .toggle_o    (dataToggle_o)
  );

  vector_mux #(.N(ENDPOINTS), .W(DATA_WID),
    .SEL_W(EP_SELECT_WID)) u_mx_rdata (
    .data_i(ep_rData_i), .sel_i(sel_q), .data_o(mx_rdata));
  vector_mux #(.N(ENDPOINTS), .W(1),
    .SEL_W(EP_SELECT_WID)) u_mx_avail (
    .data_i(ep_dataAvailable_i), .sel_i(sel_q), .data_o(mx_avail));
  vector_mux #(.N(ENDPOINTS), .W(1),
    .SEL_W(EP_SELECT_WID)) u_mx_last (
    .data_i(ep_isLast_i), .sel_i(sel_q), .data_o(mx_last));
  vector_mux #(.N(ENDPOINTS), .W(1),
    .SEL_W(EP_SELECT_WID)) u_mx_full (
    .data_i(ep_full_i), .sel_i(sel_q), .data_o(mx_full));
  vector_mux #(.N(ENDPOINTS), .W(1),
    .SEL_W(EP_SELECT_WID)) u_mx_rv (
    .data_i(ep_respValid_i), .sel_i(sel_q), .data_o(mx_rv));
  vector_mux #(.N(ENDPOINTS), .W(1),
    .SEL_W(EP_SELECT_WID)) u_mx_hs (
    .data_i(ep_respIsHandshake_i), .sel_i(sel_q), .data_o(mx_hs));
  vector_mux #(.N(ENDPOINTS), .W(2),
    .SEL_W(EP_SELECT_WID)) u_mx_pid (
    .data_i(ep_respPacketID_i), .sel_i(sel_q), .data_o(mx_pid));

  always_comb begin
    ep_transStart_o = (gotTransStartPacket_i && tok_ok
                       && !tok_stall) ? tok_oh : '0;
    ep_transDone_o    = (done_ok || abort) ? sel_oh : '0;
    ep_transSuccess_o = (done_ok && transSuccess_i) ? sel_oh : '0;
    ep_writeEn_o      = (act && writeEn_i) ? sel_oh : '0;
    ep_readEn_o       = (act && readEn_i) ? sel_oh : '0;
    ep_wData_o        = act ? wData_i : '0;

    rData_o                = '0;
    readDataAvailable_o    = 1'b0;
    readIsLastPacketByte_o = 1'b0;
    writeFull_o            = 1'b0;
    respValid_o            = 1'b0;
    respIsHandshakePID_o   = 1'b0;
    respPacketID_o         = 2'b00;
    case (state_q)
      ST_IDLE: writeFull_o = 1'b1;
      ST_ACTIVE: begin
        rData_o                = mx_rdata;
        readDataAvailable_o    = mx_avail;
        readIsLastPacketByte_o = mx_last;
        writeFull_o            = mx_full;
        respValid_o            = mx_rv;
        respIsHandshakePID_o   = mx_hs;
        respPacketID_o         = mx_pid;
      end
      ST_STALLED: begin
        respValid_o          = 1'b1;
        respIsHandshakePID_o = 1'b1;
        respPacketID_o       = PID_STALL;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usb_ep_txn_router.sv
// Self-checking bench for usb_ep_txn_router: directed scenarios plus
// randomized traffic compared against a transaction-level model.
module tb_usb_ep_txn_router;

  localparam int NE = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic clk12_i = 1'b0;
  always #5 clk12_i = ~clk12_i;

  logic rst_i;
  logic [3:0] epAddr_i;
  logic gotTransStartPacket_i, isSetup_i, isHostIn_i;
  logic transDone_i, transSuccess_i;
  logic writeEn_i, readEn_i;
  logic [DW-1:0] wData_i;
  logic writeFull_o;
  logic [DW-1:0] rData_o;
  logic readDataAvailable_o, readIsLastPacketByte_o;
  logic respValid_o, respIsHandshakePID_o;
  logic [1:0] respPacketID_o;
  logic [NE-1:0] ep_transStart_o, ep_transDone_o, ep_transSuccess_o;
  logic [NE-1:0] ep_writeEn_o, ep_readEn_o;
  logic [DW-1:0] ep_wData_o;
  logic [NE-1:0] ep_full_i, ep_dataAvailable_i, ep_isLast_i;
  logic [NE-1:0] ep_respValid_i, ep_respIsHandshake_i;
  logic [NE*DW-1:0] ep_rData_i;
  logic [2*NE-1:0] ep_respPacketID_i;
  logic [NE-1:0] setHalt_i, clearHalt_i;
  logic resetDataToggle_i;
  logic [NE-1:0] epHalted_o, dataToggle_o;

  usb_ep_txn_router #(
    .ENDPOINTS(NE), .DATA_WID(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk12_i(clk12_i), .rst_i(rst_i), .epAddr_i(epAddr_i),
    .gotTransStartPacket_i(gotTransStartPacket_i),
    .isSetup_i(isSetup_i), .isHostIn_i(isHostIn_i),
    .transDone_i(transDone_i), .transSuccess_i(transSuccess_i),
    .writeEn_i(writeEn_i), .wData_i(wData_i),
    .writeFull_o(writeFull_o), .readEn_i(readEn_i),
    .rData_o(rData_o), .readDataAvailable_o(readDataAvailable_o),
    .readIsLastPacketByte_o(readIsLastPacketByte_o),
    .respValid_o(respValid_o),
    .respIsHandshakePID_o(respIsHandshakePID_o),
    .respPacketID_o(respPacketID_o),
    .ep_transStart_o(ep_transStart_o),
    .ep_transDone_o(ep_transDone_o),
    .ep_transSuccess_o(ep_transSuccess_o),
    .ep_writeEn_o(ep_writeEn_o), .ep_wData_o(ep_wData_o),
    .ep_full_i(ep_full_i), .ep_readEn_o(ep_readEn_o),
    .ep_rData_i(ep_rData_i),
    .ep_dataAvailable_i(ep_dataAvailable_i),
    .ep_isLast_i(ep_isLast_i), .ep_respValid_i(ep_respValid_i),
    .ep_respIsHandshake_i(ep_respIsHandshake_i),
    .ep_respPacketID_i(ep_respPacketID_i),
    .setHalt_i(setHalt_i), .clearHalt_i(clearHalt_i),
    .resetDataToggle_i(resetDataToggle_i),
    .epHalted_o(epHalted_o), .dataToggle_o(dataToggle_o)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // transaction-level reference model
  typedef enum {M_IDLE, M_EP, M_STALL, M_IGN} mode_e;
  mode_e m_mode;
  int m_ep, m_age;
  logic [NE-1:0] m_tog, m_hlt;

  task automatic m_reset();
    m_mode = M_IDLE; m_ep = 0; m_age = 0;
    m_tog = '0; m_hlt = '0;
  endtask

  task automatic rnd_ep();
    ep_full_i = 4'($urandom);
    ep_dataAvailable_i = 4'($urandom);
    ep_isLast_i = 4'($urandom);
    ep_respValid_i = 4'($urandom);
    ep_respIsHandshake_i = 4'($urandom);
    ep_rData_i = 32'($urandom);
    ep_respPacketID_i = 8'($urandom);
  endtask

  task automatic quiet();
    rst_i = 1'b0; gotTransStartPacket_i = 1'b0;
    epAddr_i = 4'd0; isSetup_i = 1'b0; isHostIn_i = 1'b0;
    transDone_i = 1'b0; transSuccess_i = 1'b0;
    writeEn_i = 1'b0; readEn_i = 1'b0; wData_i = '0;
    setHalt_i = '0; clearHalt_i = '0; resetDataToggle_i = 1'b0;
    rnd_ep();
  endtask

  task automatic settle();
    logic [NE-1:0] e_st, e_dn, e_su, e_we, e_re;
    logic [DW-1:0] e_rd, e_wd;
    logic e_av, e_ls, e_fu, e_rv, e_hs;
    logic [1:0] e_pid;
    int a;
    #1;
    e_st = '0; e_dn = '0; e_su = '0; e_we = '0; e_re = '0;
    e_rd = '0; e_wd = '0; e_av = 0; e_ls = 0; e_fu = 0;
    e_rv = 0; e_hs = 0; e_pid = '0;
    a = int'(epAddr_i);
    if (gotTransStartPacket_i && a < NE
        && !(m_hlt[a] && !(isSetup_i && a == 0)))
      e_st[a] = 1'b1;
    case (m_mode)
      M_IDLE: e_fu = 1'b1;
      M_EP: begin
        e_rd = ep_rData_i[m_ep*DW +: DW];
        e_av = ep_dataAvailable_i[m_ep];
        e_ls = ep_isLast_i[m_ep];
        e_fu = ep_full_i[m_ep];
        e_rv = ep_respValid_i[m_ep];
        e_hs = ep_respIsHandshake_i[m_ep];
        e_pid = ep_respPacketID_i[2*m_ep +: 2];
        e_we[m_ep] = writeEn_i;
        e_re[m_ep] = readEn_i;
        e_wd = wData_i;
        if (gotTransStartPacket_i) e_dn[m_ep] = 1'b1;
        else if (transDone_i) begin
          e_dn[m_ep] = 1'b1;
          e_su[m_ep] = transSuccess_i;
        end else if (m_age == TO - 1) e_dn[m_ep] = 1'b1;
      end
      M_STALL: begin e_rv = 1; e_hs = 1; e_pid = 2'b11; end
      default: ;
    endcase
    chk("strobes",
      {ep_transStart_o, ep_transDone_o, ep_transSuccess_o,
       ep_writeEn_o, ep_readEn_o},
      {e_st, e_dn, e_su, e_we, e_re});
    chk("pe_side",
      {rData_o, readDataAvailable_o, readIsLastPacketByte_o,
       writeFull_o, respValid_o, respIsHandshakePID_o,
       respPacketID_o},
      {e_rd, e_av, e_ls, e_fu, e_rv, e_hs, e_pid});
    chk("wdata", ep_wData_o, e_wd);
    chk("ep_state", {epHalted_o, dataToggle_o}, {m_hlt, m_tog});
  endtask

  task automatic advance();
    logic [NE-1:0] nt, nh;
    int a, fe;
    bit s0, clr;
    a = int'(epAddr_i);
    s0 = gotTransStartPacket_i && isSetup_i && a == 0;
    fe = (m_mode == M_EP && !gotTransStartPacket_i && transDone_i
          && transSuccess_i) ? m_ep : -1;
    for (int i = 0; i < NE; i++) begin
      clr = clearHalt_i[i] || (s0 && i == 0);
      if (setHalt_i[i]) nh[i] = 1'b1;
      else if (clr) nh[i] = 1'b0;
      else nh[i] = m_hlt[i];
      if (resetDataToggle_i || clr) nt[i] = 1'b0;
      else if (i == fe) nt[i] = ~m_tog[i];
      else nt[i] = m_tog[i];
    end
    if (gotTransStartPacket_i) begin
      m_age = 0;
      if (a >= NE) m_mode = M_IGN;
      else if (m_hlt[a] && !s0) m_mode = M_STALL;
      else begin m_mode = M_EP; m_ep = a; end
    end else if (m_mode != M_IDLE) begin
      if (transDone_i || m_age == TO - 1) m_mode = M_IDLE;
      else m_age++;
    end
    m_tog = nt;
    m_hlt = nh;
    if (rst_i) m_reset();
    @(posedge clk12_i);
    @(negedge clk12_i);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic token(input int ep, input bit setup, input bit hin);
    quiet();
    gotTransStartPacket_i = 1'b1;
    epAddr_i = 4'(ep);
    isSetup_i = setup;
    isHostIn_i = hin;
  endtask

  initial begin
    quiet();
    rst_i = 1'b1;
    repeat (2) @(negedge clk12_i);
    m_reset();
    quiet();
    settle();
    chk("rst_full", writeFull_o, 1);
    chk("rst_resp", {respValid_o, respPacketID_o}, 0);
    advance();

    // IN to EP1, successful
    token(1, 0, 1); settle();
    chk("t1_start", ep_transStart_o, 4'b0010); advance();
    quiet(); settle();
    chk("t1_nostart", ep_transStart_o, 0); advance();
    quiet(); transDone_i = 1; transSuccess_i = 1; settle();
    chk("t1_done", ep_transDone_o, 4'b0010);
    chk("t1_tog_pre", dataToggle_o[1], 0); advance();
    quiet(); settle();
    chk("t1_tog_post", dataToggle_o[1], 1); advance();

    // OUT to EP2 with four bytes
    token(2, 0, 0); tick();
    for (int b = 1; b <= 4; b++) begin
      quiet(); writeEn_i = 1; wData_i = 8'(8'h11 * b); settle();
      chk("t2_wen", ep_writeEn_o, 4'b0100);
      chk("t2_wdata", ep_wData_o, 8'(8'h11 * b));
      advance();
    end
    quiet(); transDone_i = 1; transSuccess_i = 1; tick();

    // halted EP1 answers STALL
    quiet(); setHalt_i = 4'b0010; tick();
    token(1, 0, 1); settle();
    chk("t3_nostart", ep_transStart_o, 0); advance();
    quiet(); settle();
    chk("t3_resp", {respValid_o, respIsHandshakePID_o,
                    respPacketID_o}, 4'b1111);
    chk("t3_halt_on", epHalted_o[1], 1); advance();
    quiet(); transDone_i = 1; tick();
    quiet(); clearHalt_i = 4'b0010; tick();
    quiet(); settle();
    chk("t3_halt", epHalted_o[1], 0);
    chk("t3_tog", dataToggle_o[1], 0); advance();

    // invalid endpoint is ignored
    token(5, 0, 1); tick();
    quiet(); writeEn_i = 1; readEn_i = 1; settle();
    chk("t4_ignore", {respValid_o, writeFull_o,
                      readDataAvailable_o}, 0);
    chk("t4_strobes", ep_writeEn_o | ep_readEn_o, 0); advance();
    quiet(); transDone_i = 1; tick();
    quiet(); settle();
    chk("t4_idle", writeFull_o, 1); advance();

    // timeout on EP3
    token(3, 0, 0); tick();
    for (int k = 1; k < TO; k++) begin
      quiet(); settle();
      chk("t5_wait", ep_transDone_o, 0); advance();
    end
    quiet(); settle();
    chk("t5_to", ep_transDone_o, 4'b1000);
    chk("t5_succ", ep_transSuccess_o, 0); advance();
    quiet(); settle();
    chk("t5_tog", dataToggle_o[3], 0);
    chk("t5_idle", writeFull_o, 1); advance();

    // pre-emption by SETUP to EP0
    token(0, 0, 1); tick();
    quiet(); transDone_i = 1; transSuccess_i = 1; tick();
    token(1, 0, 1); tick();
    token(0, 1, 0); settle();
    chk("t6_done", ep_transDone_o, 4'b0010);
    chk("t6_succ", ep_transSuccess_o, 0);
    chk("t6_start", ep_transStart_o, 4'b0001);
    chk("t6_tog0_pre", dataToggle_o[0], 1); advance();
    quiet(); settle();
    chk("t6_tog0", dataToggle_o[0], 0); advance();

    // reset mid-transaction
    quiet(); setHalt_i = 4'b1000; tick();
    token(2, 0, 0); tick();
    quiet(); tick();
    quiet(); rst_i = 1; tick();
    quiet(); settle();
    chk("t7_full", writeFull_o, 1);
    chk("t7_halt", epHalted_o, 0);
    chk("t7_out", {respValid_o, ep_transDone_o, rData_o}, 0);
    advance();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rnd_ep();
      gotTransStartPacket_i = ($urandom_range(0, 11) == 0);
      epAddr_i = 4'($urandom_range(0, 5));
      isSetup_i = ($urandom_range(0, 3) == 0);
      isHostIn_i = 1'($urandom);
      transDone_i = ($urandom_range(0, 9) == 0);
      transSuccess_i = 1'($urandom);
      writeEn_i = 1'($urandom);
      readEn_i = 1'($urandom);
      wData_i = 8'($urandom);
      setHalt_i = ($urandom_range(0, 15) == 0) ? 4'($urandom) : '0;
      clearHalt_i = ($urandom_range(0, 15) == 0) ? 4'($urandom) : '0;
      resetDataToggle_i = ($urandom_range(0, 63) == 0);
      rst_i = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
